// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: one operand bit per cycle, shift-add multiply and
// restoring divide on magnitudes, with signs applied in a final fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wData,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic [WIDTH-1:0]     opa;
  logic [WIDTH-1:0]     opb;
  logic [2*WIDTH-1:0]   acc;
  logic [5:0]           cnt;

  logic signed [WIDTH-1:0] rs_s;
  logic signed [WIDTH-1:0] rt_s;
  logic                    rs_neg;
  logic                    rt_neg;
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          diff;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  // opa holds the multiplicand / dividend magnitude, opb the multiplier / divisor magnitude.
  always_comb begin
    rs_s    = rsData;
    rt_s    = rtData;
    rs_neg  = op[0] && (rs_s < 0);
    rt_neg  = op[0] && (rt_s < 0);
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    rem_sh  = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    diff    = rem_sh - {1'b0, opb};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hiWrite) hi <= wData;
          if (loWrite) lo <= wData;
          if (start) begin
            is_div <= op[1];
            // A zero divisor keeps the all-ones quotient unsigned.
            neg_q  <= (rs_neg ^ rt_neg) && !(op[1] && (rtData == '0));
            neg_r  <= rs_neg;
            opa    <= cond_neg(rsData, rs_neg);
            opb    <= cond_neg(rtData, rt_neg);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (is_div) begin
            if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else              acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            opa <= opa << 1;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            opb <= opb >> 1;
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
            lo <= cond_neg(acc[WIDTH-1:0], neg_q);
          end else begin
            {hi, lo} <= cond_neg_wide(acc, neg_q);
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table and random ops through a result scoreboard, plus
// hand-written sequences for reset abort, MTHI/MTLO, restart-while-busy and back-to-back starts.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] rsData = '0;
  logic [W-1:0] rtData = '0;
  logic         hiWrite = 1'b0;
  logic         loWrite = 1'b0;
  logic [W-1:0] wData = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           checks = 0;
  int           passed = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic [63:0]  exp_q[$];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  vec_t tbl[11];

  logic [1:0]   ro;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [63:0]  e;
  bit           saw;
  int           t;
  int           t1;
  int           t2;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rsData(rsData), .rtData(rtData), .hiWrite(hiWrite), .loWrite(loWrite),
    .wData(wData), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] qa;
    logic signed [31:0] qb;
    logic [63:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    qa = a;
    qb = b;
    case (o)
      2'b00: r = {32'b0, a} * {32'b0, b};
      2'b01: r = sa * sb;
      2'b10: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else r = {qa % qb, qa / qb};
      end
    endcase
    return r;
  endfunction

  // Drive one start pulse sampled at E0, then scramble the operand inputs.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input bit push);
    if (push) exp_q.push_back(exp);
    @(negedge clock);
    op = o; rsData = a; rtData = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    op = 2'($urandom_range(3));
    rsData = $urandom;
    rtData = $urandom;
  endtask

  task automatic wait_done(input string name, input int skipped);
    int n;
    int nb;
    bit got;
    logic [63:0] ex;
    n = skipped;
    nb = skipped;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clock);
      n++;
      if (busy) nb++;
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done at 34", name, n);
      if (exp_q.size() > 0) ex = exp_q.pop_front();
    end else begin
      check({name, "_busy_at_done"}, 64'(busy), 64'd0);
      check({name, "_latency"}, 64'(n), 64'd34);
      check({name, "_busy_cycles"}, 64'(nb), 64'd33);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL %s_scoreboard: got done expected no pending result", name);
      end else begin
        ex = exp_q.pop_front();
        check({name, "_hi"}, 64'(hi), 64'(ex[63:32]));
        check({name, "_lo"}, 64'(lo), 64'(ex[31:0]));
        last_hi = ex[63:32];
        last_lo = ex[31:0];
      end
      @(negedge clock);
      check({name, "_done_width"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[4]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[5]  = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    tbl[6]  = '{2'b00, 32'd3,        32'd5,        32'd0,        32'd15};
    tbl[7]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    tbl[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[9]  = '{2'b10, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    tbl[10] = '{2'b00, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};

    #1 reset = 1'b1;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      launch(tbl[i].op, tbl[i].rs, tbl[i].rt, {tbl[i].hi, tbl[i].lo}, 1'b1);
      wait_done($sformatf("vec%0d", i), 0);
    end

    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(9) + 1) : $urandom;
      launch(ro, ra, rb, ref_model(ro, ra, rb), 1'b1);
      wait_done($sformatf("rand%0d", i), 0);
    end

    // MTHI, then MTHI+MTLO together, in IDLE.
    @(negedge clock);
    hiWrite = 1'b1; wData = 32'hA5A5A5A5;
    @(posedge clock);
    #1 hiWrite = 1'b0;
    @(negedge clock);
    check("mthi_idle_hi", 64'(hi), 64'h00000000A5A5A5A5);
    check("mthi_idle_lo", 64'(lo), 64'(last_lo));
    last_hi = 32'hA5A5A5A5;
    @(negedge clock);
    hiWrite = 1'b1; loWrite = 1'b1; wData = 32'h5A5A5A5A;
    @(posedge clock);
    #1 begin hiWrite = 1'b0; loWrite = 1'b0; end
    @(negedge clock);
    check("mthilo_hi", 64'(hi), 64'h000000005A5A5A5A);
    check("mthilo_lo", 64'(lo), 64'h000000005A5A5A5A);
    last_hi = 32'h5A5A5A5A;
    last_lo = 32'h5A5A5A5A;

    // MTLO while busy is dropped; old HI/LO stay visible during RUN.
    launch(2'b00, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    repeat (5) @(negedge clock);
    loWrite = 1'b1; wData = 32'hDEADBEEF;
    @(negedge clock);
    loWrite = 1'b0;
    check("mtlo_busy_lo", 64'(lo), 64'(last_lo));
    check("mtlo_busy_hi", 64'(hi), 64'(last_hi));
    wait_done("mtlo_busy", 6);

    // start re-asserted during RUN with other operands.
    launch(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b01; rsData = 32'hFFFFFFFD; rtData = 32'd7;
    repeat (3) @(negedge clock);
    start = 1'b0;
    wait_done("restart_ignored", 8);

    // MTHI in the same cycle as start: write lands, FIX later overwrites.
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    @(negedge clock);
    op = 2'b01; rsData = 32'hFFFFFFFD; rtData = 32'd7; start = 1'b1;
    hiWrite = 1'b1; wData = 32'hA5A5A5A5;
    @(posedge clock);
    #1 begin start = 1'b0; hiWrite = 1'b0; end
    @(negedge clock);
    check("mthi_start_hi", 64'(hi), 64'h00000000A5A5A5A5);
    check("mthi_start_busy", 64'(busy), 64'd1);
    wait_done("mthi_start", 1);

    // Asynchronous reset in the middle of RUN aborts without a result.
    launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 1'b0);
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_hi", 64'(hi), 64'd0);
    check("midreset_lo", 64'(lo), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw = 1'b1;
    end
    check("midreset_no_done", 64'(saw), 64'd0);
    check("midreset_hold_lo", 64'(lo), 64'd0);
    launch(2'b00, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    wait_done("after_reset", 0);

    // start held high: back-to-back operations, done spaced by 34 cycles.
    exp_q.push_back({32'h00000001, 32'h00000000});
    exp_q.push_back({32'h00000001, 32'h00000000});
    @(negedge clock);
    op = 2'b00; rsData = 32'h00010000; rtData = 32'h00010000; start = 1'b1;
    t = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && t < 120) begin
      @(negedge clock);
      t++;
      if (done) begin
        if (t1 < 0) t1 = t;
        else begin
          t2 = t;
          start = 1'b0;
        end
        e = exp_q.pop_front();
        check("held_hi", 64'(hi), 64'(e[63:32]));
        check("held_lo", 64'(lo), 64'(e[31:0]));
      end
    end
    start = 1'b0;
    if (t2 < 0) begin
      checks++;
      $display("FAIL held_timeout: got done at %0d and %0d expected 34 and 68", t1, t2);
    end else begin
      check("held_first_latency", 64'(t1), 64'd34);
      check("held_spacing", 64'(t2 - t1), 64'd34);
    end
    repeat (2) @(negedge clock);
    check("held_idle_after", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
